// File: rtl/rd_ddr_burst_gen_pkg.sv
// Shared constants and state encoding for the DDR read-burst generator.
// Region size here matches the default top-level parameters.
package rd_ddr_burst_gen_pkg;

    localparam int LP_BEAT_BYTES   = 64;
    localparam int LP_BEAT_SHIFT   = 6;
    localparam int LP_4K_BYTES     = 4096;
    localparam int LP_REGION_BYTES = 32'h0008_0000;

    localparam logic [2:0] LP_ARSIZE  = 3'd6;
    localparam logic [1:0] LP_ARBURST = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_AR   = 3'd2,
        S_RDAT = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/rd_burst_split.sv
// Burst sizing for one AR: length limited by remaining beats, max burst,
// the next 4 KB boundary and the end of the queue's region.
module rd_burst_split
    import rd_ddr_burst_gen_pkg::*;
#(
    parameter int AW           = 32,
    parameter int QW           = 4,
    parameter int REGION_BYTES = LP_REGION_BYTES,
    parameter int MAX_BURST    = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_calc_en,
    input  logic [QW-1:0] i_queue,
    input  logic [AW-1:0] i_off,
    input  logic [AW-1:0] i_beats_left,
    output logic [AW-1:0] o_beats,
    output logic [AW-1:0] o_araddr,
    output logic [7:0]    o_arlen,
    output logic [2:0]    o_arsize,
    output logic [1:0]    o_arburst
);

    localparam int LP_REGION_SHIFT = $clog2(REGION_BYTES);

    logic [AW-1:0] w_to_4k;
    logic [AW-1:0] w_to_end;
    logic [AW-1:0] w_min;
    logic [AW-1:0] w_addr;

    // Region bases are 4 KB aligned, so offset alignment equals address alignment.
    always_comb begin
        w_to_4k  = AW'(LP_4K_BYTES / LP_BEAT_BYTES) - AW'(i_off[11:6]);
        w_to_end = (AW'(REGION_BYTES) - i_off) >> LP_BEAT_SHIFT;
        w_min    = i_beats_left;
        if (w_min > AW'(MAX_BURST)) w_min = AW'(MAX_BURST);
        if (w_min > w_to_4k)        w_min = w_to_4k;
        if (w_min > w_to_end)       w_min = w_to_end;
        w_addr   = (AW'(i_queue) << LP_REGION_SHIFT) + i_off;
    end

    assign o_beats = w_min;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_araddr  <= '0;
            o_arlen   <= '0;
            o_arsize  <= '0;
            o_arburst <= '0;
        end else if (i_calc_en) begin
            o_araddr  <= w_addr;
            o_arlen   <= w_min[7:0] - 8'd1;
            o_arsize  <= LP_ARSIZE;
            o_arburst <= LP_ARBURST;
        end
    end

endmodule

// File: rtl/rd_ddr_burst_gen.sv
// Turns {queue, byte count, flag} read jobs into AXI4 INCR bursts over each
// queue's DDR ring region and streams the returned beats to the TX path.
module rd_ddr_burst_gen
    import rd_ddr_burst_gen_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int P_DDR_LOCAL_QUEUE  = 4,
    parameter int P_QUEUE_NUM        = 8,
    parameter int P_MAX_ADDR         = 32'h003F_FFFF,
    parameter int P_MAX_BURST        = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rd_flag,
    input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_rd_queue,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_rd_byte,
    input  logic                          i_rd_byte_valid,
    output logic                          o_rd_byte_ready,
    output logic                          o_rd_queue_finish,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_m_axi_araddr,
    output logic [7:0]                    o_m_axi_arlen,
    output logic [2:0]                    o_m_axi_arsize,
    output logic [1:0]                    o_m_axi_arburst,
    output logic                          o_m_axi_arvalid,
    input  logic                          i_m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] i_m_axi_rdata,
    input  logic [1:0]                    i_m_axi_rresp,
    input  logic                          i_m_axi_rlast,
    input  logic                          i_m_axi_rvalid,
    output logic                          o_m_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] o_tx_data,
    output logic                          o_tx_valid,
    output logic                          o_tx_last,
    output logic                          o_tx_flag,
    output logic [P_DDR_LOCAL_QUEUE-1:0]  o_tx_queue,
    input  logic                          i_tx_ready,
    output logic                          o_rresp_err
);

    localparam int AW          = C_M_AXI_ADDR_WIDTH;
    localparam int QW          = P_DDR_LOCAL_QUEUE;
    localparam int LP_REGION   = (P_MAX_ADDR + 1) / P_QUEUE_NUM;
    localparam int LP_QIDX_W   = $clog2(P_QUEUE_NUM);

    state_t               r_state;
    logic                 r_ready;
    logic                 r_finish;
    logic                 r_arvalid;
    logic                 r_err;
    logic                 r_flag;
    logic [QW-1:0]        r_queue;
    logic [AW-1:0]        r_beats_left;
    logic [AW-1:0]        r_burst_cnt;
    logic [AW-1:0]        r_off [P_QUEUE_NUM];

    logic                 w_in_rdat;
    logic                 w_beat;
    logic                 w_queue_ok;
    logic                 w_calc_en;
    logic [LP_QIDX_W-1:0] w_qidx;
    logic [AW-1:0]        w_job_beats;
    logic [AW-1:0]        w_burst_beats;
    logic [AW-1:0]        w_off_inc;
    logic [AW-1:0]        w_off_next;

    assign w_in_rdat   = (r_state == S_RDAT);
    assign w_beat      = w_in_rdat && i_m_axi_rvalid && i_tx_ready;
    assign w_queue_ok  = (r_queue < QW'(P_QUEUE_NUM));
    assign w_qidx      = r_queue[LP_QIDX_W-1:0];
    assign w_calc_en   = (r_state == S_CALC) && w_queue_ok && (r_beats_left != '0);
    assign w_job_beats = (i_rd_byte >> LP_BEAT_SHIFT) + AW'(|i_rd_byte[LP_BEAT_SHIFT-1:0]);
    assign w_off_inc   = r_off[w_qidx] + AW'(LP_BEAT_BYTES);
    assign w_off_next  = (w_off_inc == AW'(LP_REGION)) ? '0 : w_off_inc;

    rd_burst_split #(
        .AW          (AW),
        .QW          (QW),
        .REGION_BYTES(LP_REGION),
        .MAX_BURST   (P_MAX_BURST)
    ) u_split (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_calc_en   (w_calc_en),
        .i_queue     (r_queue),
        .i_off       (r_off[w_qidx]),
        .i_beats_left(r_beats_left),
        .o_beats     (w_burst_beats),
        .o_araddr    (o_m_axi_araddr),
        .o_arlen     (o_m_axi_arlen),
        .o_arsize    (o_m_axi_arsize),
        .o_arburst   (o_m_axi_arburst)
    );

    // The burst beat counter, not rlast, decides where a burst ends.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_finish     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_err        <= 1'b0;
            r_flag       <= 1'b0;
            r_queue      <= '0;
            r_beats_left <= '0;
            r_burst_cnt  <= '0;
            for (int i = 0; i < P_QUEUE_NUM; i++) r_off[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_rd_byte_valid && r_ready) begin
                        r_ready      <= 1'b0;
                        r_queue      <= i_rd_queue;
                        r_flag       <= i_rd_flag;
                        r_beats_left <= w_job_beats;
                        r_state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (!w_queue_ok) begin
                        r_err    <= 1'b1;
                        r_finish <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (r_beats_left == '0) begin
                        r_finish <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_beats_left <= r_beats_left - w_burst_beats;
                        r_burst_cnt  <= w_burst_beats;
                        r_arvalid    <= 1'b1;
                        r_state      <= S_AR;
                    end
                end
                S_AR: begin
                    if (i_m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_RDAT;
                    end
                end
                S_RDAT: begin
                    if (w_beat) begin
                        r_off[w_qidx] <= w_off_next;
                        if (i_m_axi_rresp != 2'b00) r_err <= 1'b1;
                        if (r_burst_cnt == AW'(1)) begin
                            if (!i_m_axi_rlast) r_err <= 1'b1;
                            if (r_beats_left == '0) begin
                                r_finish <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
                                r_state  <= S_CALC;
                            end
                        end else begin
                            if (i_m_axi_rlast) r_err <= 1'b1;
                            r_burst_cnt <= r_burst_cnt - AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_finish <= 1'b0;
                    r_ready  <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rd_byte_ready   = r_ready;
    assign o_rd_queue_finish = r_finish;
    assign o_m_axi_arvalid   = r_arvalid;
    assign o_rresp_err       = r_err;
    assign o_m_axi_rready    = w_in_rdat && i_tx_ready;
    assign o_tx_valid        = w_in_rdat && i_m_axi_rvalid;
    assign o_tx_data         = w_in_rdat ? i_m_axi_rdata : '0;
    assign o_tx_last         = w_in_rdat && (r_burst_cnt == AW'(1)) && (r_beats_left == '0);
    assign o_tx_flag         = r_flag;
    assign o_tx_queue        = r_queue;

endmodule

// File: tb/tb_rd_ddr_burst_gen.sv
// Directed bench for rd_ddr_burst_gen: a scripted AXI slave feeds bursts and
// each job's AR addresses/lengths, beats and finish timing are checked.
module tb_rd_ddr_burst_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_flag;
    logic [3:0]   rd_queue;
    logic [31:0]  rd_byte;
    logic         rd_byte_valid;
    logic         rd_byte_ready;
    logic         rd_queue_finish;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [511:0] tx_data;
    logic         tx_valid;
    logic         tx_last;
    logic         tx_flag;
    logic [3:0]   tx_queue;
    logic         tx_ready;
    logic         rresp_err;

    rd_ddr_burst_gen dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_rd_flag        (rd_flag),
        .i_rd_queue       (rd_queue),
        .i_rd_byte        (rd_byte),
        .i_rd_byte_valid  (rd_byte_valid),
        .o_rd_byte_ready  (rd_byte_ready),
        .o_rd_queue_finish(rd_queue_finish),
        .o_m_axi_araddr   (araddr),
        .o_m_axi_arlen    (arlen),
        .o_m_axi_arsize   (arsize),
        .o_m_axi_arburst  (arburst),
        .o_m_axi_arvalid  (arvalid),
        .i_m_axi_arready  (arready),
        .i_m_axi_rdata    (rdata),
        .i_m_axi_rresp    (rresp),
        .i_m_axi_rlast    (rlast),
        .i_m_axi_rvalid   (rvalid),
        .o_m_axi_rready   (rready),
        .o_tx_data        (tx_data),
        .o_tx_valid       (tx_valid),
        .o_tx_last        (tx_last),
        .o_tx_flag        (tx_flag),
        .o_tx_queue       (tx_queue),
        .i_tx_ready       (tx_ready),
        .o_rresp_err      (rresp_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fin_cnt = 0;
    int exp_fin = 0;
    int tx_hs = 0;
    int beat_id = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_len_q[$];
    logic        cur_flag;
    logic [3:0]  cur_q;

    always @(posedge clk) begin
        cyc++;
        if (rd_queue_finish) fin_cnt++;
        if (tx_valid && tx_ready) tx_hs++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic accept_job(input logic [3:0] q, input logic [31:0] bytes, input logic flag);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!rd_byte_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_ready", 64'(rd_byte_ready), 64'd1);
        rd_queue = q;
        rd_byte = bytes;
        rd_flag = flag;
        rd_byte_valid = 1'b1;
        cur_q = q;
        cur_flag = flag;
        @(posedge clk);
        @(negedge clk);
        rd_byte_valid = 1'b0;
        #1;
        check("ready_drop", 64'(rd_byte_ready), 64'd0);
    endtask

    task automatic do_ar(input logic [31:0] exp_addr, input logic [31:0] exp_len);
        int n;
        n = 0;
        #1;
        while (!arvalid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("ar_seen", 64'(arvalid), 64'd1);
        check("araddr", 64'(araddr), 64'(exp_addr));
        check("arlen", 64'(arlen), 64'(exp_len));
        check("arsize", 64'(arsize), 64'd6);
        check("arburst", 64'(arburst), 64'd1);
        @(negedge clk);
        #1;
        check("ar_hold_valid", 64'(arvalid), 64'd1);
        check("ar_hold_addr", 64'(araddr), 64'(exp_addr));
        arready = 1'b1;
        @(posedge clk);
        #1;
        arready = 1'b0;
        check("ar_drop", 64'(arvalid), 64'd0);
    endtask

    task automatic do_beats(input int len, input bit final_b, input bit toggle,
                            input int last_at, input int n_send);
        for (int k = 0; k < n_send; k++) begin
            bit done;
            int guard;
            done = 1'b0;
            guard = 0;
            while (!done && guard < 100) begin
                @(negedge clk);
                rvalid = 1'b1;
                rresp = 2'b00;
                rdata = {16{beat_id[31:0]}};
                rlast = (k == last_at);
                tx_ready = toggle ? cyc[0] : 1'b1;
                #1;
                check("rready", 64'(rready), 64'(tx_ready));
                check("tx_valid", 64'(tx_valid), 64'd1);
                if (tx_ready) begin
                    check("tx_data", tx_data[63:0], {beat_id[31:0], beat_id[31:0]});
                    check("tx_last", 64'(tx_last), 64'(final_b && (k == len)));
                    check("tx_flag", 64'(tx_flag), 64'(cur_flag));
                    check("tx_queue", 64'(tx_queue), 64'(cur_q));
                end
                @(posedge clk);
                if (tx_ready) begin
                    done = 1'b1;
                    beat_id++;
                end
                guard++;
            end
            check("beat_taken", 64'(done), 64'd1);
        end
        @(negedge clk);
        rvalid = 1'b0;
        rlast = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic check_finish();
        #1;
        check("finish_pulse", 64'(rd_queue_finish), 64'd1);
        check("finish_no_ar", 64'(arvalid), 64'd0);
        exp_fin++;
        @(negedge clk);
        #1;
        check("finish_drop", 64'(rd_queue_finish), 64'd0);
        check("ready_back", 64'(rd_byte_ready), 64'd1);
        check("finish_count", 64'(fin_cnt), 64'(exp_fin));
    endtask

    task automatic run_job(input logic [3:0] q, input logic [31:0] bytes,
                           input logic flag, input bit toggle);
        int n;
        accept_job(q, bytes, flag);
        n = exp_addr_q.size();
        if (n == 0) begin
            check("zero_no_ar", 64'(arvalid), 64'd0);
            check("zero_no_fin", 64'(rd_queue_finish), 64'd0);
            @(negedge clk);
        end
        for (int b = 0; b < n; b++) begin
            do_ar(exp_addr_q[b], exp_len_q[b]);
            do_beats(int'(exp_len_q[b]), b == n - 1, toggle, int'(exp_len_q[b]), int'(exp_len_q[b]) + 1);
        end
        check_finish();
        exp_addr_q.delete();
        exp_len_q.delete();
    endtask

    task automatic push_burst(input logic [31:0] addr, input logic [31:0] len);
        exp_addr_q.push_back(addr);
        exp_len_q.push_back(len);
    endtask

    initial begin
        int hs0;
        rst = 1'b1;
        rd_flag = 1'b0;
        rd_queue = '0;
        rd_byte = '0;
        rd_byte_valid = 1'b0;
        arready = 1'b0;
        rdata = '0;
        rresp = 2'b00;
        rlast = 1'b0;
        rvalid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 64'(rd_byte_ready), 64'd1);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_finish", 64'(rd_queue_finish), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_err", 64'(rresp_err), 64'd0);
        rst = 1'b0;

        // queue 2, 256 B: single burst, then confirm offset 0x100
        push_burst(32'h0010_0000, 32'd3);
        run_job(4'd2, 32'd256, 1'b0, 1'b0);
        push_burst(32'h0010_0100, 32'd0);
        run_job(4'd2, 32'd64, 1'b0, 1'b0);

        // queue 0, 100 B rounds up to 2 beats, flag set
        push_burst(32'h0000_0000, 32'd1);
        run_job(4'd0, 32'd100, 1'b1, 1'b0);
        push_burst(32'h0000_0080, 32'd0);
        run_job(4'd0, 32'd64, 1'b0, 1'b0);

        // queue 1: advance to 0xF80, then a 512 B job splits at 4 KB
        push_burst(32'h0008_0000, 32'd61);
        run_job(4'd1, 32'd3968, 1'b0, 1'b0);
        push_burst(32'h0008_0F80, 32'd1);
        push_burst(32'h0008_1000, 32'd5);
        run_job(4'd1, 32'd512, 1'b1, 1'b0);

        // queue 3: advance to 0x7FFC0, then wrap at the region end
        for (int i = 0; i < 128; i++)
            push_burst(32'h0018_0000 + 32'(i) * 32'h1000, (i == 127) ? 32'd62 : 32'd63);
        run_job(4'd3, 32'h0007_FFC0, 1'b0, 1'b0);
        push_burst(32'h001F_FFC0, 32'd0);
        push_burst(32'h0018_0000, 32'd0);
        run_job(4'd3, 32'd128, 1'b0, 1'b0);
        push_burst(32'h0018_0040, 32'd0);
        run_job(4'd3, 32'd64, 1'b1, 1'b0);

        // queue 4, 8 KB with TX backpressure toggling
        hs0 = tx_hs;
        push_burst(32'h0020_0000, 32'd63);
        push_burst(32'h0020_1000, 32'd63);
        run_job(4'd4, 32'd8192, 1'b1, 1'b1);
        check("beats_8k", 64'(tx_hs - hs0), 64'd128);

        // zero-byte job: no AR, finish 2 cycles after accept
        run_job(4'd7, 32'd0, 1'b0, 1'b0);
        check("err_clean", 64'(rresp_err), 64'd0);

        // early rlast: counter still governs, error flagged
        accept_job(4'd5, 32'd128, 1'b0);
        do_ar(32'h0028_0000, 32'd1);
        do_beats(1, 1'b1, 1'b0, 0, 2);
        check_finish();
        check("err_early_rlast", 64'(rresp_err), 64'd1);

        // reset in the middle of a 1 KB job on queue 6
        push_burst(32'h0030_0000, 32'd1);
        run_job(4'd6, 32'd128, 1'b0, 1'b0);
        accept_job(4'd6, 32'd1024, 1'b1);
        do_ar(32'h0030_0080, 32'd15);
        do_beats(15, 1'b1, 1'b0, 15, 5);
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(rd_byte_ready), 64'd1);
        check("midrst_arvalid", 64'(arvalid), 64'd0);
        check("midrst_tx_valid", 64'(tx_valid), 64'd0);
        check("midrst_err", 64'(rresp_err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("midrst_no_finish", 64'(fin_cnt), 64'(exp_fin));
        push_burst(32'h0030_0000, 32'd0);
        run_job(4'd6, 32'd64, 1'b0, 1'b0);

        // out-of-range queue: no AR, finished, error flagged
        run_job(4'd9, 32'd256, 1'b0, 1'b0);
        check("err_bad_queue", 64'(rresp_err), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=0x%0h exp=0x%0h", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
